his_peak_reader: RTL
====================

# his_peak_reader

Histogram readout engine for the dToF histogram memory: the read side of the TDC-event histogram writer. After an acquisition completes, it scans each pixel's histogram in the completed bank, finds the peak bin (maximum count), and streams one peak record per pixel downstream over a valid/ready handshake. It sits between the histogram BRAM read port and the depth-calculation stage.

## Interface
Parameters:
- `NB`, 4: bin address width; bins per histogram `BIN_NUM = 2**NB`.
- `PIXEL_NUM`, 4: pixels per RAM bank.
- `PEAK_W`, 8: bin count width (matches histogram word width).
- `ADDR_W`, `$clog2(2*PIXEL_NUM*BIN_NUM)`: read address width; two banks.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `res` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse, acquisition finished; begin scan.
- `his_sel` in 1: bank to read, sampled on accepted `start`.
- `rd_en` out 1: BRAM read strobe.
- `rd_addr` out ADDR_W: `bank*PIXEL_NUM*BIN_NUM + pixel*BIN_NUM + bin`.
- `rd_data` in PEAK_W: BRAM data, valid exactly 1 cycle after `rd_en`.
- `clr_we` out 1: write-zero strobe to the same address, only with `HIS_CLEAR_ON_READ_EN`.
- `out_valid` out 1: peak record valid.
- `out_ready` in 1: downstream accepts.
- `out_pixel` out `$clog2(PIXEL_NUM)`: pixel index of the record.
- `out_peak_bin` out NB: bin index of the maximum.
- `out_peak_count` out PEAK_W: count at that bin.
- `out_empty` out 1: histogram had all-zero bins.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse after the last record is accepted.

## Operation
- FSM states: IDLE, READ, DRAIN, EMIT, FINISH.
- IDLE: `start`=1 latches `his_sel`, clears pixel/bin counters and goes to READ. `start` is ignored in every other state.
- READ: asserts `rd_en` each cycle with `bin` 0..BIN_NUM-1. Returning `rd_data` feeds the running max. After bin BIN_NUM-1 is issued, goes to DRAIN.
- DRAIN: one cycle to absorb the last read, then EMIT.
- Running max update: `rd_data > max` strictly replaces max and index. Ties keep the lowest bin. Max resets to 0 and index to 0 at each pixel start.
- EMIT: `out_valid`=1 with fields stable until `out_valid && out_ready`.
  - On handshake, if `pixel < PIXEL_NUM-1`: increment pixel and go to READ.
  - Otherwise go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `out_empty`=1 iff the final max is 0. In that case `out_peak_bin`=0 and `out_peak_count`=0.
- Counts never saturate or wrap: compare only, no arithmetic on `rd_data`.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `clr_we`=0, `out_valid`=0, all out fields 0, `busy`=0, `done`=0, FSM=IDLE.
- `start` at cycle t puts the first `rd_en` at t+1.
- Per pixel, with `out_ready` held high: BIN_NUM read cycles, 1 drain cycle, 1 emit cycle, giving BIN_NUM+2 cycles.
- Full scan with ready high: `PIXEL_NUM*(BIN_NUM+2)` cycles from first `rd_en` to last handshake. `done` follows one cycle later.
- `busy` is high from the cycle after accepted `start` through the FINISH cycle.
- Backpressure: `out_ready`=0 stalls in EMIT indefinitely. No reads are issued while stalled.
- Reset asserted mid-scan: immediate return to reset values. No partial record and no `done`.

## Configuration
- `HIS_CLEAR_ON_READ_EN` defined:
  - `clr_we` pulses one cycle after each `rd_en`, addressed to the just-read bin (address held one cycle via a delayed register). This leaves the bank zeroed for the next acquisition.
  - Per-pixel timing is unchanged; the write overlaps the next read, so the BRAM must be dual-port.
- Not defined: `clr_we` is tied to 0 and the bank is left intact.

## Structure
- Shared package `his_pkg`: FSM state encoding, default `NB`/`PIXEL_NUM`/`PEAK_W`, and the address-composition function. The histogram writer shares this package.
- One sub-module, `peak_tracker`: holds the running max and index, with inputs clear, sample valid, data and bin index. It implements the strict-greater, lowest-index-tie rule.

## Test plan
All scenarios use NB=4 (16 bins), PIXEL_NUM=4, PEAK_W=8 and a BRAM model with 1-cycle read latency.
- **Single peak:** pixel 0 bin 9 = 37, other bins ≤5, `out_ready`=1 → record {pixel 0, bin 9, count 37, empty 0}. Four records total; `done` pulses at cycle 73 after `start`.
- **Tie:** bins 3 and 12 both 200, the rest 0 → bin 3, count 200.
- **Empty histogram:** all zeros → bin 0, count 0, `out_empty`=1.
- **Bank select:** `his_sel`=1 → first `rd_addr`=64, last=127.
- **Backpressure and start during busy:**
  - `out_ready` low for 10 cycles in EMIT → fields stable, no `rd_en`, record delivered once after ready rises.
  - `start` pulsed while `busy` → ignored.
- **Reset and clear-on-read:**
  - `res` low at cycle 20 of the scan → all outputs 0, no `done`. A new `start` rescans from pixel 0.
  - With `HIS_CLEAR_ON_READ_EN`: after the scan, every bank-0 word reads 0.

Source files
------------

// File: rtl/his_pkg.sv
// Shared histogram package: FSM encoding, default geometry and BRAM address composition.
// Used by both the histogram writer and the peak reader.
package his_pkg;

    localparam int HIS_NB        = 4;
    localparam int HIS_PIXEL_NUM = 4;
    localparam int HIS_PEAK_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_EMIT,
        S_FINISH
    } his_state_e;

    // Two banks laid out back to back, each PIXEL_NUM histograms of BIN_NUM words.
    function automatic int unsigned his_addr(input int unsigned bank,
                                             input int unsigned pixel,
                                             input int unsigned bin,
                                             input int unsigned pixel_num,
                                             input int unsigned bin_num);
        return bank * pixel_num * bin_num + pixel * bin_num + bin;
    endfunction

endpackage

// File: rtl/his_peak_reader_peak_tracker.sv
// Running maximum of one histogram: strictly-greater replaces, so ties keep the lowest bin.
module peak_tracker #(
    parameter int NB     = 4,
    parameter int PEAK_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              clr,
    input  logic              smp_vld,
    input  logic [PEAK_W-1:0] smp_data,
    input  logic [NB-1:0]     smp_bin,
    output logic [PEAK_W-1:0] max_count,
    output logic [NB-1:0]     max_bin
);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            max_count <= '0;
            max_bin   <= '0;
        end else if (clr) begin
            max_count <= '0;
            max_bin   <= '0;
        end else if (smp_vld && (smp_data > max_count)) begin
            max_count <= smp_data;
            max_bin   <= smp_bin;
        end
    end

endmodule

// File: rtl/his_peak_reader.sv
// Histogram readout: scans each pixel histogram of the selected bank and streams its peak.
// Optional HIS_CLEAR_ON_READ_EN zeroes every word one cycle after it is read.
module his_peak_reader
    import his_pkg::*;
#(
    parameter int NB        = HIS_NB,
    parameter int PIXEL_NUM = HIS_PIXEL_NUM,
    parameter int PEAK_W    = HIS_PEAK_W,
    parameter int ADDR_W    = $clog2(2 * PIXEL_NUM * (2 ** NB))
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         start,
    input  logic                         his_sel,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [PEAK_W-1:0]            rd_data,
    output logic                         clr_we,
    output logic [ADDR_W-1:0]            clr_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(PIXEL_NUM)-1:0] out_pixel,
    output logic [NB-1:0]                out_peak_bin,
    output logic [PEAK_W-1:0]            out_peak_count,
    output logic                         out_empty,
    output logic                         busy,
    output logic                         done
);

    localparam int BIN_NUM = 2 ** NB;
    localparam int PX_W    = $clog2(PIXEL_NUM);

    his_state_e        state, state_nx;
    logic              bank;
    logic [PX_W-1:0]   pixel;
    logic [NB-1:0]     bin, bin_d;
    logic              smp_vld;
    logic              trk_clr;
    logic              last_bin, last_px;
    logic [PEAK_W-1:0] max_count;
    logic [NB-1:0]     max_bin;

    assign last_bin = (bin == NB'(BIN_NUM - 1));
    assign last_px  = (pixel == PX_W'(PIXEL_NUM - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_READ;
            S_READ:   if (last_bin) state_nx = S_DRAIN;
            S_DRAIN:  state_nx = S_EMIT;
            S_EMIT:   if (out_ready) state_nx = last_px ? S_FINISH : S_READ;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state   <= S_IDLE;
            bank    <= 1'b0;
            pixel   <= '0;
            bin     <= '0;
            bin_d   <= '0;
            smp_vld <= 1'b0;
        end else begin
            state   <= state_nx;
            smp_vld <= rd_en;
            bin_d   <= bin;
            case (state)
                S_IDLE: if (start) begin
                    bank  <= his_sel;
                    pixel <= '0;
                    bin   <= '0;
                end
                S_READ: bin <= bin + 1'b1;
                S_EMIT: if (out_ready && !last_px) pixel <= pixel + 1'b1;
                default: ;
            endcase
        end
    end

    // Fresh maximum every time a pixel scan begins.
    assign trk_clr = (state_nx == S_READ) && (state != S_READ);

    peak_tracker #(.NB(NB), .PEAK_W(PEAK_W)) u_trk (
        .clk       (clk),
        .res       (res),
        .clr       (trk_clr),
        .smp_vld   (smp_vld),
        .smp_data  (rd_data),
        .smp_bin   (bin_d),
        .max_count (max_count),
        .max_bin   (max_bin)
    );

    assign rd_en   = (state == S_READ);
    assign rd_addr = rd_en ? ADDR_W'(his_addr(32'(bank), 32'(pixel), 32'(bin),
                                              PIXEL_NUM, BIN_NUM)) : '0;

`ifdef HIS_CLEAR_ON_READ_EN
    logic [ADDR_W-1:0] clr_addr_q;
    always_ff @(posedge clk or negedge res) begin
        if (!res) clr_addr_q <= '0;
        else      clr_addr_q <= rd_addr;
    end
    assign clr_we   = smp_vld;
    assign clr_addr = smp_vld ? clr_addr_q : '0;
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    // Record fields read as zero outside EMIT.
    assign out_valid      = (state == S_EMIT);
    assign out_pixel      = out_valid ? pixel : '0;
    assign out_peak_bin   = out_valid ? max_bin : '0;
    assign out_peak_count = out_valid ? max_count : '0;
    assign out_empty      = out_valid && (max_count == '0);
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_FINISH);

endmodule
